// File: rtl/pmem_line_responder_if.sv
// rtl/pmem_line_responder_if.sv - cache-to-memory line request/response bus
// Requester drives the master side, the memory responder the slave side.
interface pmem_line_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - fixed-latency line-store memory responder
// Accepts one line read/write at a time and completes it LATENCY cycles later.
module pmem_line_responder #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pmem_line_responder_if.slave bus,
  output logic                 busy,
  output logic                 req_conflict,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_GAP} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [7:0]              r_cnt;
  logic [INDEX_BITS-1:0]   r_index;
  logic                    r_is_write;
  logic [127:0]            r_wdata;
  logic [127:0]            r_rdata;
  logic [127:0]            r_mem [0:(1<<INDEX_BITS)-1];

  logic                    w_accept;
  logic                    w_last_busy;
  logic [INDEX_BITS-1:0]   w_index;
  logic                    w_unused_addr;

  assign w_accept      = (r_state == S_IDLE) && (bus.pmem_read || bus.pmem_write);
  assign w_last_busy   = (r_state == S_BUSY) && (r_cnt == 8'd1);
  assign w_index       = bus.pmem_address[INDEX_BITS+3:4];
  // Offset bits and aliased upper bits do not select a line.
  assign w_unused_addr = ^bus.pmem_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_BUSY;
      S_BUSY: if (w_last_busy) w_next_state = S_RESP;
      S_RESP: w_next_state = S_GAP;
      S_GAP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 8'd0;
      r_index      <= '0;
      r_is_write   <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      req_conflict <= 1'b0;
      read_count   <= 16'd0;
      write_count  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_cnt      <= 8'(LATENCY - 1);
        r_index    <= w_index;
        r_is_write <= bus.pmem_write;
        r_wdata    <= bus.pmem_wdata;
        if (bus.pmem_read && bus.pmem_write) begin
          req_conflict <= 1'b1;
        end
      end
      if (r_state == S_BUSY && !w_last_busy) begin
        r_cnt <= r_cnt - 8'd1;
      end
      // Read data is registered on entry to RESP so it is valid for the whole pulse.
      if (w_last_busy && !r_is_write) begin
        r_rdata <= r_mem[r_index];
      end
      if (r_state == S_RESP) begin
        if (r_is_write) begin
          write_count <= write_count + 16'd1;
        end else begin
          read_count <= read_count + 16'd1;
        end
      end
    end
  end

  // Store has no reset; a reset on the RESP edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_RESP && r_is_write) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  assign bus.pmem_resp  = (r_state == S_RESP);
  assign bus.pmem_rdata = r_rdata;
  assign busy           = (r_state == S_BUSY) || (r_state == S_RESP);

endmodule
